// File: rtl/req_queue4.sv
// Four-requester pending-request queue feeding a 4-way rotating-priority arbiter.
// Optional per-requester starvation watchdog enabled by defining REQ_QUEUE_STARVE_EN.
module req_queue4 #(
  parameter int DEPTH        = 4,
  parameter int CW           = $clog2(DEPTH + 1),
  parameter int STARVE_LIMIT = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      push,
  input  logic            flush,
  output logic [3:0]      full,
  output logic [3:0]      req,
  output logic            en,
  input  logic [3:0]      gnt,
  input  logic            ready,
  output logic            issue_valid,
  output logic [1:0]      issue_id,
  output logic [4*CW-1:0] pend_cnt,
  output logic            overflow,
  output logic            gnt_err
`ifdef REQ_QUEUE_STARVE_EN
  ,
  output logic [3:0]      starve
`endif
);

  if (DEPTH < 1 || DEPTH > 15 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("req_queue4: DEPTH must be 1..15 and STARVE_LIMIT at least 1");
  end

  logic [CW-1:0] cnt      [4];
  logic [CW-1:0] cnt_next [4];
  logic [3:0]    inc;
  logic [3:0]    dec;
  logic [3:0]    drop;
  logic          gnt_onehot;
  logic          gnt_hit;
  logic          accept;
  logic          illegal;
  logic [1:0]    gnt_idx;

  assign en = ready & ~flush;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    full     = '0;
    req      = '0;
    pend_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]               = (cnt[i] == CW'(DEPTH));
      req[i]                = (cnt[i] != '0);
      pend_cnt[i*CW +: CW]  = cnt[i];
    end
  end

  // A grant is legal only if it names exactly one requester that actually has work pending.
  assign gnt_onehot = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);
  assign gnt_hit    = |(gnt & req);
  assign accept     = en & gnt_onehot & gnt_hit;
  assign illegal    = en & (gnt != 4'd0) & ~(gnt_onehot & gnt_hit);

  assign inc  = push & ~full;
  assign drop = push & full;
  assign dec  = accept ? gnt : 4'd0;

  always_comb begin
    gnt_idx = 2'd0;
    case (gnt)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = cnt[i];
      if (flush)
        cnt_next[i] = '0;
      else if (inc[i] && !dec[i])
        cnt_next[i] = cnt[i] + CW'(1);
      else if (dec[i] && !inc[i])
        cnt_next[i] = cnt[i] - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      issue_valid <= 1'b0;
      issue_id    <= 2'd0;
      overflow    <= 1'b0;
      gnt_err     <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_next[i];
      issue_valid <= accept;
      if (accept)  issue_id <= gnt_idx;
      if (|drop)   overflow <= 1'b1;
      if (illegal) gnt_err  <= 1'b1;
    end
  end

`ifdef REQ_QUEUE_STARVE_EN
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] age [4];

  // Age counts cycles a requester waits unserved; any service or emptying restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (flush || dec[i] || !req[i] || cnt_next[i] == '0)
          age[i] <= '0;
        else if (age[i] != AW'(STARVE_LIMIT))
          age[i] <= age[i] + AW'(1);
      end
    end
  end

  always_comb begin
    starve = '0;
    for (int i = 0; i < 4; i++) starve[i] = (age[i] == AW'(STARVE_LIMIT));
  end
`endif

endmodule
